// File: rtl/matrix_div_pkg.sv
// Shared types and saturation helpers for the matrix row divider.
package matrix_div_pkg;

  typedef enum logic [2:0] {
    STATE_IDLE = 3'd0,
    STATE_LOAD = 3'd1,
    STATE_DIV  = 3'd2,
    STATE_OUT  = 3'd3,
    STATE_DONE = 3'd4
  } state_e;

  localparam logic [2:0] ST_IDLE = STATE_IDLE;
  localparam logic [2:0] ST_LOAD = STATE_LOAD;
  localparam logic [2:0] ST_DIV  = STATE_DIV;
  localparam logic [2:0] ST_OUT  = STATE_OUT;
  localparam logic [2:0] ST_DONE = STATE_DONE;

  typedef enum logic {
    ROUND_TRUNC     = 1'b0,
    ROUND_HALF_AWAY = 1'b1
  } round_mode_e;

  function automatic longint sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/matrix_row_divider_if.sv
// Job control and row streaming bus between a row producer/consumer and the divider.
interface matrix_row_divider_if #(
  parameter int ROWS          = 3,
  parameter int COLS          = 3,
  parameter int WIDTH         = 16,
  parameter int DIVISOR_WIDTH = 8
);
  localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                            start;
  logic signed [DIVISOR_WIDTH-1:0] divisor;
  logic                            round_mode;
  logic                            in_valid;
  logic                            in_ready;
  logic [COLS-1:0][WIDTH-1:0]      in_row;
  logic                            out_valid;
  logic                            out_ready;
  logic [COLS-1:0][WIDTH-1:0]      out_row;
  logic [IDX_W-1:0]                out_row_idx;
  logic                            out_last;
  logic                            done;
  logic                            busy;
  logic                            div_by_zero;

  modport slave (
    input  start, divisor, round_mode, in_valid, in_row, out_ready,
    output in_ready, out_valid, out_row, out_row_idx, out_last, done, busy, div_by_zero
  );

  modport master (
    output start, divisor, round_mode, in_valid, in_row, out_ready,
    input  in_ready, out_valid, out_row, out_row_idx, out_last, done, busy, div_by_zero
  );
endinterface

// File: rtl/matrix_row_divider_div_lane.sv
// One element lane: restoring divide on magnitudes, then sign, rounding and saturation.
module div_lane
  import matrix_div_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int DIVISOR_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            load,
  input  logic                            step,
  input  logic                            fix,
  input  logic signed [WIDTH-1:0]         dividend,
  input  logic signed [DIVISOR_WIDTH-1:0] divisor,
  input  logic                            round_mode,
  output logic signed [WIDTH-1:0]         result
);
  localparam int DW = DIVISOR_WIDTH;
  localparam logic signed [WIDTH-1:0] MAX_V = WIDTH'(sat_max(WIDTH));
  localparam logic signed [WIDTH-1:0] MIN_V = WIDTH'(sat_min(WIDTH));
  localparam logic [WIDTH:0] NEG_LIMIT = (WIDTH+1)'(1) << (WIDTH - 1);
  localparam logic [WIDTH:0] POS_LIMIT = NEG_LIMIT - (WIDTH+1)'(1);

  logic [WIDTH-1:0]        quo_r;
  logic [DW-1:0]           rem_r;
  logic                    neg_r;
  logic signed [WIDTH-1:0] result_r;

  logic [DW-1:0]           dmag_s;
  logic [WIDTH-1:0]        amag_s;
  logic [DW:0]             shifted_s;
  logic [DW-1:0]           diff_s;
  logic                    ge_s;
  logic                    round_up_s;
  logic [WIDTH:0]          mag_s;
  logic signed [WIDTH-1:0] fixed_s;

  // Magnitudes, one restoring step, and the final signed/saturated quotient.
  always_comb begin
    dmag_s     = divisor[DW-1] ? DW'(-divisor) : DW'(divisor);
    amag_s     = dividend[WIDTH-1] ? WIDTH'(-dividend) : WIDTH'(dividend);
    shifted_s  = {rem_r, quo_r[WIDTH-1]};
    ge_s       = (shifted_s >= {1'b0, dmag_s});
    diff_s     = shifted_s[DW-1:0] - dmag_s;
    round_up_s = (round_mode == ROUND_HALF_AWAY) && ({rem_r, 1'b0} >= {1'b0, dmag_s});
    mag_s      = {1'b0, quo_r} + (WIDTH+1)'(round_up_s);
    fixed_s    = {WIDTH{1'b0}};
    if (dmag_s == {DW{1'b0}}) begin
      fixed_s = neg_r ? MIN_V : MAX_V;
    end else if (neg_r ^ divisor[DW-1]) begin
      // A magnitude of exactly 2^(WIDTH-1) still negates cleanly to MIN.
      fixed_s = (mag_s > NEG_LIMIT) ? MIN_V : WIDTH'(-mag_s[WIDTH-1:0]);
    end else begin
      fixed_s = (mag_s > POS_LIMIT) ? MAX_V : mag_s[WIDTH-1:0];
    end
  end

  // Lane state: capture the dividend, shift out one quotient bit per step, register result.
  always_ff @(posedge clk) begin
    if (reset) begin
      quo_r    <= {WIDTH{1'b0}};
      rem_r    <= {DW{1'b0}};
      neg_r    <= 1'b0;
      result_r <= {WIDTH{1'b0}};
    end else if (load) begin
      quo_r <= amag_s;
      rem_r <= {DW{1'b0}};
      neg_r <= dividend[WIDTH-1];
    end else if (step) begin
      rem_r <= ge_s ? diff_s : shifted_s[DW-1:0];
      quo_r <= {quo_r[WIDTH-2:0], ge_s};
    end else if (fix) begin
      result_r <= fixed_s;
    end
  end

  assign result = result_r;
endmodule

// File: rtl/matrix_row_divider.sv
// Divides each row of a ROWS x COLS matrix by one signed divisor, one row at a time.
module matrix_row_divider
  import matrix_div_pkg::*;
#(
  parameter int ROWS          = 3,
  parameter int COLS          = 3,
  parameter int WIDTH         = 16,
  parameter int DIVISOR_WIDTH = 8
) (
  input logic                  clk,
  input logic                  reset,
  matrix_row_divider_if.slave  bus
);
  localparam int IDX_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int STEP_W = $clog2(WIDTH + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(ROWS - 1);
  localparam logic [STEP_W-1:0] FIX_STEP = STEP_W'(WIDTH);

  logic [2:0]                      state_r;
  logic [IDX_W-1:0]                row_idx_r;
  logic [IDX_W-1:0]                out_row_idx_r;
  logic [STEP_W-1:0]               step_r;
  logic signed [DIVISOR_WIDTH-1:0] divisor_r;
  logic                            mode_r;
  logic                            dbz_r;
  logic                            in_ready_r;
  logic                            out_valid_r;
  logic                            out_last_r;
  logic                            done_r;
  logic                            busy_r;

  logic                            in_fire_s;
  logic                            lane_step_s;
  logic                            lane_fix_s;
  logic signed [WIDTH-1:0]         lane_result_s [COLS];

  assign in_fire_s   = bus.in_valid & in_ready_r;
  assign lane_step_s = (state_r == ST_DIV) && (step_r != FIX_STEP);
  assign lane_fix_s  = (state_r == ST_DIV) && (step_r == FIX_STEP);

  // Job sequencing: accept start, stream rows through the lanes, signal completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      row_idx_r     <= {IDX_W{1'b0}};
      out_row_idx_r <= {IDX_W{1'b0}};
      step_r        <= {STEP_W{1'b0}};
      divisor_r     <= {DIVISOR_WIDTH{1'b0}};
      mode_r        <= 1'b0;
      dbz_r         <= 1'b0;
      in_ready_r    <= 1'b0;
      out_valid_r   <= 1'b0;
      out_last_r    <= 1'b0;
      done_r        <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            divisor_r  <= bus.divisor;
            mode_r     <= bus.round_mode;
            dbz_r      <= (bus.divisor == {DIVISOR_WIDTH{1'b0}});
            row_idx_r  <= {IDX_W{1'b0}};
            in_ready_r <= 1'b1;
            busy_r     <= 1'b1;
            state_r    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (in_fire_s) begin
            in_ready_r <= 1'b0;
            step_r     <= {STEP_W{1'b0}};
            state_r    <= ST_DIV;
          end
        end
        ST_DIV: begin
          // WIDTH shift steps, then the fix-up cycle lands the result with out_valid.
          if (step_r == FIX_STEP) begin
            out_valid_r   <= 1'b1;
            out_row_idx_r <= row_idx_r;
            out_last_r    <= (row_idx_r == LAST_IDX);
            state_r       <= ST_OUT;
          end else begin
            step_r <= step_r + STEP_W'(1);
          end
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            if (row_idx_r == LAST_IDX) begin
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              row_idx_r  <= row_idx_r + IDX_W'(1);
              in_ready_r <= 1'b1;
              state_r    <= ST_LOAD;
            end
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
          done_r      <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_lane
    div_lane #(
      .WIDTH         (WIDTH),
      .DIVISOR_WIDTH (DIVISOR_WIDTH)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .load       (in_fire_s),
      .step       (lane_step_s),
      .fix        (lane_fix_s),
      .dividend   (bus.in_row[c]),
      .divisor    (divisor_r),
      .round_mode (mode_r),
      .result     (lane_result_s[c])
    );
    assign bus.out_row[c] = lane_result_s[c];
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_row_idx = out_row_idx_r;
  assign bus.out_last    = out_last_r;
  assign bus.done        = done_r;
  assign bus.busy        = busy_r;
  assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_matrix_row_divider.sv
// Randomized and directed bench for matrix_row_divider against an arithmetic reference model.
module tb_matrix_row_divider;
  localparam int ROWS  = 3;
  localparam int COLS  = 3;
  localparam int WIDTH = 16;
  localparam int DW    = 8;
  localparam int LAT   = WIDTH + 1;
  localparam int MAXV  = (1 <<< (WIDTH - 1)) - 1;
  localparam int MINV  = -(1 <<< (WIDTH - 1));

  typedef logic [COLS-1:0][WIDTH-1:0] row_t;
  typedef struct packed {
    row_t       row;
    logic [1:0] idx;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  matrix_row_divider_if #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH), .DIVISOR_WIDTH(DW)) bus ();

  matrix_row_divider #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH), .DIVISOR_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int     checks = 0;
  int     errors = 0;
  exp_t   exp_q[$];
  int     model_div = 0;
  bit     model_mode = 1'b0;
  bit     model_dbz = 1'b0;
  int     rows_sent = 0;
  int     done_cnt = 0;
  int     jobs_done = 0;
  bit     check_tput = 1'b0;
  longint cyc = 0;
  longint last_hs = 0;
  bit     ready_random = 1'b0;
  bit     ready_force = 1'b1;

  function automatic int model_q(input int a, input int d, input bit mode);
    int q;
    int r;
    if (d == 0) return (a >= 0) ? MAXV : MINV;
    q = a / d;
    r = a % d;
    if (mode && (2 * ((r < 0) ? -r : r) >= ((d < 0) ? -d : d)))
      q = q + (((a < 0) != (d < 0)) ? -1 : 1);
    if (q > MAXV) q = MAXV;
    if (q < MINV) q = MINV;
    return q;
  endfunction

  function automatic row_t mk(input int a, input int b, input int c);
    row_t r;
    r[0] = WIDTH'(a);
    r[1] = WIDTH'(b);
    r[2] = WIDTH'(c);
    return r;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = ready_random ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  // Compare process: every cycle out_valid is up, the front expected row must be on the bus.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!reset) begin
      check("div_by_zero", bus.div_by_zero, model_dbz);
      if (bus.done) done_cnt++;
      if (bus.out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: got row %h idx %0d with nothing expected", bus.out_row, bus.out_row_idx);
        end else begin
          e = exp_q[0];
          if ({bus.out_row, bus.out_row_idx, bus.out_last} !== {e.row, e.idx, e.last}) begin
            errors++;
            $display("FAIL out_row: got %h idx %0d last %0d expected %h idx %0d last %0d",
                     bus.out_row, bus.out_row_idx, bus.out_last, e.row, e.idx, e.last);
          end
          check("in_ready_in_out", bus.in_ready, 0);
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            if (check_tput && e.idx != 2'd0) check("throughput", cyc - last_hs, WIDTH + 3);
            last_hs = cyc;
          end
        end
      end
    end
  end

  task automatic start_job(input int d, input bit mode);
    int n = 0;
    while (bus.busy && n < 200) begin @(posedge clk); #1; n++; end
    check("start_wait_idle", bus.busy, 0);
    bus.start = 1'b1;
    bus.divisor = DW'(d);
    bus.round_mode = mode;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.divisor = DW'($urandom);
    bus.round_mode = 1'($urandom);
    model_div = d;
    model_mode = mode;
    model_dbz = (d == 0);
    rows_sent = 0;
    check("busy_after_start", bus.busy, 1);
    check("in_ready_after_start", bus.in_ready, 1);
  endtask

  task automatic send_row(input row_t row, input bit use_lit, input row_t lit, input bit check_lat);
    exp_t e;
    int n = 0;
    while (!bus.in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: in_ready %0d after %0d cycles, required 1", bus.in_ready, n);
      return;
    end
    bus.in_row = row;
    bus.in_valid = 1'b1;
    for (int c = 0; c < COLS; c++)
      e.row[c] = use_lit ? lit[c] : WIDTH'(model_q(int'($signed(row[c])), model_div, model_mode));
    e.idx = 2'(rows_sent);
    e.last = (rows_sent == ROWS - 1);
    exp_q.push_back(e);
    rows_sent++;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_row = row_t'({$urandom, $urandom});
    if (check_lat) begin
      repeat (LAT - 1) begin @(posedge clk); #1; end
      check("latency_early", bus.out_valid, 0);
      @(posedge clk);
      #1;
      check("latency_rise", bus.out_valid, 1);
    end
  endtask

  task automatic finish_job();
    int n = 0;
    while (bus.busy && n < 300) begin @(posedge clk); #1; n++; end
    jobs_done++;
    check("job_end_busy", bus.busy, 0);
    check("done_pulses", done_cnt, jobs_done);
    check("rows_drained", exp_q.size(), 0);
  endtask

  task automatic stray_start();
    bus.start = 1'b1;
    bus.divisor = 8'sd7;
    bus.round_mode = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_row"}, bus.out_row, 0);
    check({tag, "_out_row_idx"}, bus.out_row_idx, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_last"}, bus.out_last, 0);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_div_by_zero"}, bus.div_by_zero, 0);
  endtask

  initial begin
    row_t z;
    int   dsel[8];
    int   d;
    int   v[3];
    z = '0;
    dsel = '{0, 1, -1, 2, -3, 7, 127, -128};
    bus.start = 1'b0;
    bus.divisor = '0;
    bus.round_mode = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_row = '0;

    check("pin_trunc", model_q(-70, 3, 1'b0), -23);
    check("pin_round", model_q(-20, 3, 1'b1), -7);
    check("pin_minneg1", model_q(-32768, -1, 1'b0), 32767);
    check("pin_dbz_neg", model_q(-5, 0, 1'b0), -32768);
    check("pin_dbz_zero", model_q(0, 0, 1'b1), 32767);

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    check_tput = 1'b1;
    start_job(2, 1'b0);
    send_row(mk(10, 20, 30), 1'b1, mk(5, 10, 15), 1'b1);
    send_row(mk(40, 50, 60), 1'b1, mk(20, 25, 30), 1'b1);
    send_row(mk(70, 80, 90), 1'b1, mk(35, 40, 45), 1'b1);
    finish_job();
    check_tput = 1'b0;

    start_job(3, 1'b0);
    send_row(mk(-10, -20, -30), 1'b1, mk(-3, -6, -10), 1'b1);
    send_row(mk(40, -50, 60), 1'b1, mk(13, -16, 20), 1'b1);
    send_row(mk(-70, 80, -90), 1'b1, mk(-23, 26, -30), 1'b1);
    finish_job();

    start_job(3, 1'b1);
    send_row(mk(-10, -20, -30), 1'b1, mk(-3, -7, -10), 1'b1);
    send_row(mk(40, -50, 60), 1'b1, mk(13, -17, 20), 1'b1);
    send_row(mk(-70, 80, -90), 1'b1, mk(-23, 27, -30), 1'b1);
    finish_job();

    start_job(-1, 1'b1);
    send_row(mk(-32768, 100, -7), 1'b1, mk(32767, -100, 7), 1'b1);
    send_row(mk(32767, -32767, 0), 1'b0, z, 1'b1);
    send_row(mk(1, -1, 12345), 1'b0, z, 1'b1);
    finish_job();

    start_job(0, 1'b0);
    send_row(mk(5, -5, 0), 1'b1, mk(32767, -32768, 32767), 1'b1);
    send_row(mk(-32768, 32767, -1), 1'b1, mk(-32768, 32767, -32768), 1'b1);
    send_row(mk(1, 2, 3), 1'b0, z, 1'b1);
    finish_job();
    repeat (3) @(posedge clk);
    #1;
    check("dbz_sticky", bus.div_by_zero, 1);

    // Output stall: the row must sit untouched for ten cycles with no new input accepted.
    ready_force = 1'b0;
    start_job(5, 1'b0);
    check("dbz_cleared", bus.div_by_zero, 0);
    send_row(mk(100, -101, 7), 1'b0, z, 1'b1);
    repeat (10) begin
      @(posedge clk);
      #1;
      check("stall_valid", bus.out_valid, 1);
      check("stall_in_ready", bus.in_ready, 0);
    end
    ready_force = 1'b1;
    send_row(mk(-3, 4, 32767), 1'b0, z, 1'b1);
    send_row(mk(-32768, 10, -10), 1'b0, z, 1'b1);
    finish_job();

    start_job(2, 1'b0);
    stray_start();
    send_row(mk(11, -11, 1001), 1'b0, z, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    stray_start();
    bus.in_valid = 1'b0;
    send_row(mk(-9, 9, 300), 1'b0, z, 1'b1);
    send_row(mk(7, 8, -9), 1'b0, z, 1'b1);
    finish_job();

    // Reset in the middle of dividing row 1, then restart immediately.
    start_job(0, 1'b0);
    send_row(mk(1, 2, 3), 1'b0, z, 1'b1);
    send_row(mk(4, 5, 6), 1'b0, z, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    model_dbz = 1'b0;
    exp_q.delete();
    check_all_zero("mid_div_reset");
    reset = 1'b0;
    start_job(-3, 1'b1);
    send_row(mk(-10, 20, 31), 1'b0, z, 1'b1);
    send_row(mk(100, -100, 5), 1'b0, z, 1'b1);
    send_row(mk(-32768, 32767, 2), 1'b0, z, 1'b1);
    finish_job();

    ready_random = 1'b1;
    for (int j = 0; j < 10; j++) begin
      d = ($urandom_range(0, 1) == 0) ? dsel[$urandom_range(0, 7)] : int'($urandom_range(0, 255)) - 128;
      start_job(d, 1'($urandom_range(0, 1)));
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          case ($urandom_range(0, 9))
            0:       v[c] = MINV;
            1:       v[c] = MAXV;
            2:       v[c] = int'($urandom_range(0, 20)) - 10;
            default: v[c] = int'($urandom_range(0, 65535)) - 32768;
          endcase
        end
        send_row(mk(v[0], v[1], v[2]), 1'b0, z, 1'($urandom_range(0, 1)));
      end
      finish_job();
    end
    ready_random = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
